// File: rtl/ram_row_loader_pkg.sv
// Shared constants, helpers and state encoding for the RAM row loader.
package ram_row_loader_pkg;

  localparam int DEF_DATA_WIDTH = 96;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_MEM_SIZE   = 128;

  // Index width that stays legal when a row holds a single word.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WORDS_PER_ROW = DEF_DATA_WIDTH / DEF_WORD_WIDTH;
  localparam int WORD_IDX_W    = idx_width(WORDS_PER_ROW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ram_row_loader_row_word_packer.sv
// Packs consecutive words into one row, first word in the MSB slice.
module row_word_packer
  import ram_row_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int WPR        = WORDS_PER_ROW,
  parameter int IDX_W      = WORD_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] row,
  output logic                  row_complete
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPR - 1);

  logic [DATA_WIDTH-1:0] row_q, row_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shifted;

  assign shifted      = {row_q[DATA_WIDTH-WORD_WIDTH-1:0], word};
  assign row          = shifted;
  assign row_complete = word_valid && !clear && (idx_q == LAST_IDX);

  // Next row contents and word index: shift on each accepted word.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    row_d = row_q;
    idx_d = idx_q;
    if (clear) begin
      row_d = '0;
      idx_d = '0;
    end else if (word_valid) begin
      row_d = shifted;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // Shift register and word counter; reset drops any partial row.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      row_q <= '0;
      idx_q <= '0;
    end else begin
      row_q <= row_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/ram_row_loader.sv
// Streams words into packed rows and writes them to consecutive RAM addresses.
module ram_row_loader
  import ram_row_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iBaseAddress,
  input  logic [ADDR_WIDTH-1:0] iRowCount,
  input  logic                  iWordValid,
  input  logic [WORD_WIDTH-1:0] iWord,
  output logic                  oWordReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oDataOut,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oError
);

  localparam int WPR   = DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_W = idx_width(WPR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] row_idx_q, row_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic                  empty_done_q, empty_done_d;

  logic                  pack_clear;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] packed_row;
  logic                  row_complete;
  logic [ADDR_WIDTH:0]   span;

  assign oWordReady    = (state_q == ST_FILL);
  assign oBusy         = (state_q != ST_IDLE);
  assign oDone         = (state_q == ST_DONE) || empty_done_q;
  assign oError        = err_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oDataOut      = data_q;

  assign handshake = iWordValid && oWordReady;
  // One extra bit so base+count cannot wrap before the bound check.
  assign span      = {1'b0, iBaseAddress} + {1'b0, iRowCount};

  row_word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .WPR        (WPR),
    .IDX_W      (IDX_W)
  ) u_packer (
    .clk          (Clock),
    .rst          (Reset),
    .clear        (pack_clear),
    .word_valid   (handshake),
    .word         (iWord),
    .row          (packed_row),
    .row_complete (row_complete)
  );

  // Next-state logic: request check, row write issue and load termination.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    count_d      = count_q;
    row_idx_d    = row_idx_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = 1'b0;
    err_d        = 1'b0;
    empty_done_d = 1'b0;
    pack_clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          base_d  = iBaseAddress;
          count_d = iRowCount;
          if (span > (ADDR_WIDTH+1)'(MEM_SIZE)) begin
            err_d = 1'b1;
          end else if (iRowCount == '0) begin
            empty_done_d = 1'b1;
          end else begin
            state_d    = ST_FILL;
            row_idx_d  = '0;
            pack_clear = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (row_complete) begin
          we_d      = 1'b1;
          addr_d    = base_q + row_idx_q;
          data_d    = packed_row;
          row_idx_d = row_idx_q + 1'b1;
          if (row_idx_q == count_q - 1'b1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset also cancels a pending write strobe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      count_q      <= '0;
      row_idx_q    <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      empty_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      count_q      <= count_d;
      row_idx_q    <= row_idx_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      err_q        <= err_d;
      empty_done_q <= empty_done_d;
    end
  end

endmodule

// File: tb/tb_ram_row_loader.sv
// Randomized and directed bench for ram_row_loader against a word-count model.
module tb_ram_row_loader;

  localparam int DW  = 96;
  localparam int WW  = 32;
  localparam int AW  = 16;
  localparam int MS  = 128;
  localparam int WPR = DW / WW;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iStart;
  logic [AW-1:0] iBaseAddress;
  logic [AW-1:0] iRowCount;
  logic          iWordValid;
  logic [WW-1:0] iWord;
  logic          oWordReady;
  logic          oWriteEnable;
  logic [AW-1:0] oWriteAddress;
  logic [DW-1:0] oDataOut;
  logic          oBusy;
  logic          oDone;
  logic          oError;

  ram_row_loader dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iStart        (iStart),
    .iBaseAddress  (iBaseAddress),
    .iRowCount     (iRowCount),
    .iWordValid    (iWordValid),
    .iWord         (iWord),
    .oWordReady    (oWordReady),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oDataOut      (oDataOut),
    .oBusy         (oBusy),
    .oDone         (oDone),
    .oError        (oError)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a load is described by base, rows and words accepted so far.
  bit            m_active;
  int            m_base;
  int            m_rows;
  int            m_acc;
  bit            m_pend_we;
  bit            m_pend_last;
  bit            m_err;
  bit            m_empty;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [WW-1:0] m_words[$];
  int            seq_word;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    m_active    = 1'b0;
    m_base      = 0;
    m_rows      = 0;
    m_acc       = 0;
    m_pend_we   = 1'b0;
    m_pend_last = 1'b0;
    m_err       = 1'b0;
    m_empty     = 1'b0;
    m_addr      = '0;
    m_data      = '0;
    m_words.delete();
  endtask

  // One clock cycle, called at a falling edge: check outputs, drive inputs, advance.
  task automatic cycle(input logic start, input int b, input int c,
                       input logic valid, input logic [WW-1:0] w);
    bit hs;
    bit ready_exp;
    bit was_idle;
    ready_exp = m_active && (m_acc < WPR * m_rows);
    check("ready", DW'(oWordReady), DW'(ready_exp));
    check("we",    DW'(oWriteEnable), DW'(m_pend_we));
    check("done",  DW'(oDone), DW'((m_pend_we && m_pend_last) || m_empty));
    check("error", DW'(oError), DW'(m_err));
    check("busy",  DW'(oBusy), DW'(m_active));
    check("addr",  DW'(oWriteAddress), DW'(m_addr));
    check("data",  oDataOut, m_data);

    iStart       = start;
    iBaseAddress = AW'(b);
    iRowCount    = AW'(c);
    iWordValid   = valid;
    iWord        = w;

    hs       = valid && ready_exp;
    was_idle = !m_active;
    if (m_pend_we && m_pend_last) m_active = 1'b0;
    m_pend_we   = 1'b0;
    m_pend_last = 1'b0;
    m_err       = 1'b0;
    m_empty     = 1'b0;
    if (hs) begin
      m_words.push_back(w);
      m_acc++;
      if (m_words.size() == WPR) begin
        m_data = '0;
        for (int j = 0; j < WPR; j++) m_data = {m_data[DW-WW-1:0], m_words[j]};
        m_words.delete();
        m_addr      = AW'(m_base + m_acc / WPR - 1);
        m_pend_we   = 1'b1;
        m_pend_last = (m_acc == WPR * m_rows);
      end
    end
    if (start && was_idle) begin
      if (b + c > MS) m_err = 1'b1;
      else if (c == 0) m_empty = 1'b1;
      else begin
        m_active = 1'b1;
        m_base   = b;
        m_rows   = c;
        m_acc    = 0;
        m_words.delete();
      end
    end
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 0, 0, 1'b0, WW'($urandom));
  endtask

  // pattern: 0 continuous, 1 alternating, 2 random. mid_at: cycle to re-pulse iStart (-1 none).
  task automatic run_load(input int b, input int c, input int pattern, input bit seq,
                          input int mid_at);
    logic          v;
    logic [WW-1:0] w;
    int            i;
    cycle(1'b1, b, c, 1'b0, WW'($urandom));
    i = 0;
    while ((m_active || m_pend_we || m_err || m_empty) && i < 400) begin
      case (pattern)
        0:       v = 1'b1;
        1:       v = (i % 2 == 0);
        default: v = ($urandom_range(0, 99) < 70);
      endcase
      w = seq ? WW'(seq_word) : WW'($urandom);
      if (seq && v) seq_word++;
      cycle(i == mid_at, 50, 2, v, w);
      i++;
    end
    check("load_bounded", DW'(i < 400), DW'(1));
    idle_cycle();
  endtask

  initial begin
    Reset        = 1'b1;
    iStart       = 1'b0;
    iBaseAddress = '0;
    iRowCount    = '0;
    iWordValid   = 1'b0;
    iWord        = '0;
    model_clear();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    idle_cycle();

    // Two rows at base 5 with words 1..6 back to back.
    seq_word = 1;
    run_load(5, 2, 0, 1'b1, -1);
    check("row5_data", oDataOut, {32'd4, 32'd5, 32'd6});

    // Single row with gaps in valid.
    run_load(10, 1, 1, 1'b1, -1);

    // Out of range, exact upper bound, and empty request.
    run_load(126, 3, 0, 1'b0, -1);
    run_load(125, 3, 0, 1'b0, -1);
    check("top_addr", DW'(oWriteAddress), DW'(127));
    run_load(40, 0, 0, 1'b0, -1);

    // Reset after two words of the second row, then a fresh load at base 0.
    cycle(1'b1, 20, 3, 1'b0, '0);
    for (int k = 0; k < WPR + 2; k++) cycle(1'b0, 0, 0, 1'b1, WW'($urandom));
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    model_clear();
    seq_word = 32'h100;
    run_load(0, 1, 0, 1'b1, -1);

    // iStart re-pulsed mid-load with another base is ignored.
    run_load(30, 2, 0, 1'b0, 2);

    // Randomized loads, including some out-of-range and empty requests.
    for (int n = 0; n < 25; n++) begin
      run_load($urandom_range(0, 130), $urandom_range(0, 5), 2, 1'b0,
               $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 8)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_row_loader.md
# ram_row_loader

Streaming write-side front end for the dual-read-port data RAM. It accepts 32-bit words over a valid/ready handshake and packs each group of WORDS_PER_ROW words into one DATA_WIDTH row. It drives the RAM write port (write enable, write address, data) at consecutive addresses starting from a programmed base. It sits between the host/DMA load path and the RAM, and reports completion and out-of-range requests to the control unit.

## Interface
- DATA_WIDTH, 96 (`DATA_ROW_WIDTH): RAM row width.
- WORD_WIDTH, 32: input word width. DATA_WIDTH must be an integer multiple of it.
- ADDR_WIDTH, 16 (`DATA_ADDRESS_WIDTH): RAM address width.
- MEM_SIZE, 128: number of RAM rows. It is the upper bound for base+count.
- Clock  in  1  single clock. All logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle request to begin a load. It is ignored unless the block is in IDLE.
- iBaseAddress  in  ADDR_WIDTH  first row address. Sampled with iStart.
- iRowCount  in  ADDR_WIDTH  number of rows to load. Sampled with iStart.
- iWordValid  in  1  input word valid.
- iWord  in  WORD_WIDTH  input word.
- oWordReady  out  1  the block accepts iWord this cycle. Reset value 0.
- oWriteEnable  out  1  RAM write strobe, one cycle per row. Reset value 0.
- oWriteAddress  out  ADDR_WIDTH  RAM write address. Reset value 0.
- oDataOut  out  DATA_WIDTH  RAM write data. Reset value 0.
- oBusy  out  1  a load is in progress. Reset value 0.
- oDone  out  1  one-cycle pulse at load completion. Reset value 0.
- oError  out  1  one-cycle pulse when a request is rejected. Reset value 0.

## Operation
- A handshake occurs when iWordValid and oWordReady are both high at a rising edge.
- States: IDLE, FILL, DONE.
- **IDLE**
  - oWordReady=0, oBusy=0.
  - On iStart, the block latches base and count.
  - If base+count > MEM_SIZE (computed in ADDR_WIDTH+1 bits): pulse oError next cycle and stay in IDLE. No writes are issued.
  - If count==0: pulse oDone next cycle and stay in IDLE.
  - Otherwise: go to FILL, set word index=0 and row index=0.
- **FILL**
  - oWordReady=1, oBusy=1.
  - Each handshake shifts the word into the row being assembled. Word 0 goes to the MSB slice [DATA_WIDTH-1 -: WORD_WIDTH]; the last word goes to the LSB slice.
  - When the word index reaches WORDS_PER_ROW-1 and a handshake occurs:
    - oDataOut is loaded with the completed row.
    - oWriteAddress is loaded with base+row index.
    - oWriteEnable is set to 1 for the next cycle only.
    - The word index resets to 0 and the row index increments.
  - If that row was row count-1, go to DONE. Otherwise stay in FILL.
- **DONE**
  - oWordReady=0, oBusy=1.
  - The final oWriteEnable is visible this cycle, and oDone=1 in the same cycle.
  - Next state is IDLE.
- iStart is ignored while in FILL or DONE.
- Gaps in iWordValid stall packing without losing state.
- Reset at any point returns to IDLE at the next edge:
  - All outputs take their reset values.
  - Any partial row is discarded.
  - A write strobe that was pending is cancelled.
- oDataOut and oWriteAddress hold their last values between strobes.

## Timing
- Latency: the row write strobe appears exactly 1 cycle after the handshake of that row's last word.
- Throughput: one word per cycle sustained, i.e. one row every WORDS_PER_ROW cycles. Back-to-back rows must not stall oWordReady.
- oDone coincides with the last oWriteEnable. oBusy falls the cycle after oDone.
- With iStart at cycle t and a valid request, oWordReady rises at cycle t+1.
- oError and oDone for rejected or empty requests appear at t+1.
- An address never exceeds MEM_SIZE-1 and never wraps.

## Structure
- Shared package: WORDS_PER_ROW = DATA_WIDTH/WORD_WIDTH, the state encoding (IDLE, FILL, DONE), and a word-index width of clog2(WORDS_PER_ROW).
- One natural sub-module, row_word_packer: a shift register with word counter that outputs the completed row and a row_complete flag. The FSM, address counter and range check stay in the top module.

## Test plan
- Load 2 rows at base 5, words 1..6 continuous:
  - Writes at addr 5 = {1,2,3} and addr 6 = {4,5,6}, each 1 cycle after words 3 and 6.
  - oDone coincides with the second strobe.
- Single row with iWordValid toggling 1,0,1,0,1:
  - Exactly one strobe, 1 cycle after the third accepted word.
  - No strobe during the gaps.
- Base 126, count 3 (MEM_SIZE 128): oError pulses at t+1, oBusy stays 0, no strobes.
- Count 0: oDone pulses at t+1, no strobes, oWordReady stays 0.
- Reset asserted after 2 words of the second row:
  - Next cycle all outputs are 0 and the block is in IDLE.
  - A new load at base 0 writes a row built only from fresh words.
- iStart pulsed mid-load with a different base: it is ignored, and addresses continue from the original base.
